// File: rtl/wb_line_port_pkg.sv
// Shared types for the Wishbone line port: line/word containers and the port FSM states.
package wb_line_port_pkg;

  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2
  } wb_port_state_t;

endpackage

// File: rtl/wb_lane_mux.sv
// Byte-lane steering between a pipeline word and a Wishbone line: builds SEL and the
// write line from a line offset, and extracts the addressed word or byte from a read line.
module wb_lane_mux
  import wb_line_port_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int WORD_W = 16
) (
  input  logic [$clog2(LINE_W/8)-1:0] byte_idx,
  input  logic                        is_byte,
  input  logic [WORD_W-1:0]           wdata,
  input  logic [LINE_W-1:0]           line_in,
  output logic [LINE_W/8-1:0]         sel,
  output logic [LINE_W-1:0]           line_out,
  output logic [WORD_W-1:0]           rdata
);

  localparam int NL  = LINE_W / 8;
  localparam int BPW = WORD_W / 8;
  localparam int OFF = $clog2(NL);
  localparam int WB  = $clog2(BPW);

  localparam logic [NL-1:0] WORD_SEL = {{(NL-BPW){1'b0}}, {BPW{1'b1}}};
  localparam logic [NL-1:0] BYTE_SEL = NL'(1);

  logic [OFF-1:0]    word_idx;
  logic [LINE_W-1:0] word_line;
  logic [LINE_W-1:0] byte_line;

  // Word accesses drop the sub-word address bits; byte accesses use the full offset.
  always_comb begin
    word_idx  = byte_idx >> WB;
    word_line = line_in >> (int'(word_idx) * WORD_W);
    byte_line = line_in >> (int'(byte_idx) * 8);
    if (is_byte) begin
      sel      = BYTE_SEL << byte_idx;
      line_out = LINE_W'(wdata[7:0]) << (int'(byte_idx) * 8);
      rdata    = WORD_W'(byte_line[7:0]);
    end else begin
      sel      = WORD_SEL << (int'(word_idx) * BPW);
      line_out = LINE_W'(wdata) << (int'(word_idx) * WORD_W);
      rdata    = word_line[WORD_W-1:0];
    end
  end

endmodule

// File: rtl/wb_line_port.sv
// Memory-stage bus port: accepts one load/store at a time and runs it as a Wishbone line
// cycle, with RTY backoff/retry, an ACK timeout, and a pipeline stall while busy.
module wb_line_port
  import wb_line_port_pkg::*;
#(
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_byte,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [WORD_W-1:0]   resp_rdata,
  output logic                stall,
  output logic [ADDR_W-1:0]   ADR,
  output logic [LINE_W-1:0]   DAT_M,
  input  logic [LINE_W-1:0]   DAT_S,
  output logic [LINE_W/8-1:0] SEL,
  output logic                CYC,
  output logic                STB,
  output logic                WE,
  input  logic                ACK,
  input  logic                RTY
);

  localparam int NL  = LINE_W / 8;
  localparam int OFF = $clog2(NL);
  localparam int RW  = $clog2(MAX_RETRY + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  wb_port_state_t    state_q, state_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [OFF-1:0]    off_q, off_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_out_q, we_out_d;
  logic [NL-1:0]     sel_q, sel_d;
  logic [LINE_W-1:0] dat_m_q, dat_m_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              idle;
  logic [OFF-1:0]    lane_off;
  logic              lane_byte;
  logic [NL-1:0]     lane_sel;
  logic [LINE_W-1:0] lane_line;
  logic [WORD_W-1:0] lane_rdata;

  assign idle      = (state_q == IDLE);
  assign req_ready = idle;
  assign stall     = !idle || (req_valid && req_ready);

  // In IDLE the mux steers the incoming request; afterwards it extracts read data for the held one.
  assign lane_off  = idle ? req_addr[OFF-1:0] : off_q;
  assign lane_byte = idle ? req_byte : byte_q;

  wb_lane_mux #(
    .LINE_W (LINE_W),
    .WORD_W (WORD_W)
  ) u_lane_mux (
    .byte_idx (lane_off),
    .is_byte  (lane_byte),
    .wdata    (req_wdata),
    .line_in  (DAT_S),
    .sel      (lane_sel),
    .line_out (lane_line),
    .rdata    (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    byte_d       = byte_q;
    off_d        = off_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_out_d     = we_out_q;
    sel_d        = sel_q;
    dat_m_d      = dat_m_q;
    adr_d        = adr_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = BUS;
          we_d     = req_we;
          byte_d   = req_byte;
          off_d    = req_addr[OFF-1:0];
          retry_d  = '0;
          tmo_d    = '0;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          we_out_d = req_we;
          sel_d    = lane_sel;
          dat_m_d  = lane_line;
          adr_d    = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        end
      end
      BUS: begin
        if (ACK) begin
          state_d      = IDLE;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          we_out_d     = 1'b0;
          resp_valid_d = 1'b1;
          if (!we_q) begin
            rdata_d = lane_rdata;
          end
        end else if (RTY && (retry_q != RW'(MAX_RETRY))) begin
          state_d = BACKOFF;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          retry_d = retry_q + RW'(1);
          tmo_d   = '0;
        end else if (RTY || (tmo_q == TW'(TIMEOUT))) begin
          state_d      = IDLE;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          we_out_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      BACKOFF: begin
        state_d = BUS;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      off_q        <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_out_q     <= 1'b0;
      sel_q        <= '0;
      dat_m_q      <= '0;
      adr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      off_q        <= off_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_out_q     <= we_out_d;
      sel_q        <= sel_d;
      dat_m_q      <= dat_m_d;
      adr_q        <= adr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign CYC        = cyc_q;
  assign STB        = stb_q;
  assign WE         = we_out_q;
  assign SEL        = sel_q;
  assign DAT_M      = dat_m_q;
  assign ADR        = adr_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_wb_line_port.sv
// Scoreboard bench for wb_line_port: directed requests push expected responses,
// a monitor pops and compares them whenever resp_valid is seen.
module tb_wb_line_port;
  import wb_line_port_pkg::*;

  localparam int LINE_W = 128;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic              req_byte = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [WORD_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_err;
  logic [WORD_W-1:0] resp_rdata;
  logic              stall;
  logic [ADDR_W-1:0] ADR;
  logic [LINE_W-1:0] DAT_M;
  logic [LINE_W-1:0] DAT_S;
  logic [15:0]       SEL;
  logic              CYC, STB, WE;
  logic              ACK = 1'b0;
  logic              RTY = 1'b0;

  always #5 clk = ~clk;

  wb_line_port #(
    .LINE_W    (LINE_W),
    .WORD_W    (WORD_W),
    .ADDR_W    (ADDR_W),
    .MAX_RETRY (3),
    .TIMEOUT   (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .stall      (stall),
    .ADR        (ADR),
    .DAT_M      (DAT_M),
    .DAT_S      (DAT_S),
    .SEL        (SEL),
    .CYC        (CYC),
    .STB        (STB),
    .WE         (WE),
    .ACK        (ACK),
    .RTY        (RTY)
  );

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    bit          chkData;
    int          lat;
    int          acceptCnt;
    string       name;
  } expT;

  expT      sb[$];
  int       checks = 0;
  int       errors = 0;
  int       cycleCnt = 0;
  int       rtyLeft = 0;
  bit       silent = 1'b0;
  int       stbRun = 0;
  lc3b_line slaveData = '0;

  assign DAT_S = slaveData;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Registered slave: answers in the second consecutive STB cycle with RTY (while any are scripted) or ACK.
  always @(negedge clk) begin
    ACK = 1'b0;
    RTY = 1'b0;
    if (STB) stbRun++;
    else stbRun = 0;
    if (STB && stbRun == 2 && !silent) begin
      if (rtyLeft > 0) begin
        RTY = 1'b1;
        rtyLeft--;
      end else begin
        ACK = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    expT e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_err"}, resp_err, e.err);
        if (e.chkData) checkOutput({e.name, "_rdata"}, resp_rdata, e.rdata);
        if (e.lat != 0) checkOutput({e.name, "_latency"}, cycleCnt - e.acceptCnt, e.lat);
      end
    end
  end

  task automatic applyStimulus(
    input string       name,
    input bit          we,
    input bit          isByte,
    input logic [15:0] addr,
    input logic [15:0] wdata,
    input lc3b_line    dats,
    input int          rtys,
    input bit          sil,
    input bit          expErr,
    input logic [15:0] expData,
    input bit          chkData,
    input int          expLat,
    input logic [15:0] expAdr,
    input logic [15:0] expSel,
    input lc3b_line    expDatM,
    input bit          chkDatM,
    input int          expGaps
  );
    expT e;
    int  gaps;
    bit  done;
    @(negedge clk);
    slaveData = dats;
    rtyLeft   = rtys;
    silent    = sil;
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = isByte;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    checkOutput({name, "_req_ready"}, req_ready, 1);
    checkOutput({name, "_stall_accept"}, stall, 1);
    e.err       = expErr;
    e.rdata     = expData;
    e.chkData   = chkData;
    e.lat       = expLat;
    e.acceptCnt = cycleCnt;
    e.name      = name;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hFFFF;
    checkOutput({name, "_cyc"}, CYC, 1);
    checkOutput({name, "_stb"}, STB, 1);
    checkOutput({name, "_we"}, WE, we);
    checkOutput({name, "_adr"}, ADR, expAdr);
    checkOutput({name, "_sel"}, SEL, expSel);
    if (chkDatM) checkOutput({name, "_dat_m"}, DAT_M, expDatM);
    gaps = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (resp_valid) done = 1'b1;
      else if (!STB) gaps++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_resp_timeout: got no resp_valid, expected one within 400 cycles", name);
    end else begin
      checkOutput({name, "_stb_gaps"}, gaps, expGaps);
      checkOutput({name, "_ready_on_resp"}, req_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_cyc", CYC, 0);
    checkOutput("rst_stb", STB, 0);
    checkOutput("rst_we", WE, 0);
    checkOutput("rst_sel", SEL, 0);
    checkOutput("rst_dat_m", DAT_M, 0);
    checkOutput("rst_adr", ADR, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_rdata", resp_rdata, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_stall", stall, 0);
    rst_n = 1'b1;

    applyStimulus("word_load", 0, 0, 16'h0006, 16'h0000,
                  128'h1111_2222_3333_4444_BEEF_6666_7777_8888, 0, 0,
                  0, 16'hBEEF, 1, 3, 16'h0000, 16'h00C0, '0, 0, 0);

    applyStimulus("byte_store", 1, 1, 16'h001B, 16'h12A5,
                  128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 0,
                  0, 16'hBEEF, 1, 3, 16'h0010, 16'h0800,
                  128'h00000000_A5000000_00000000_00000000, 1, 0);

    applyStimulus("byte_load", 0, 1, 16'h0003, 16'h0000,
                  128'hDEADBEEF_CAFEBABE_01234567_F0ABCDEF, 0, 0,
                  0, 16'h00F0, 1, 3, 16'h0000, 16'h0008, '0, 0, 0);

    applyStimulus("rty2_load", 0, 0, 16'h0012, 16'h0000,
                  128'h00000000_00000000_00000000_CAFE5678, 2, 0,
                  0, 16'hCAFE, 1, 9, 16'h0010, 16'h000C, '0, 0, 2);

    applyStimulus("rty_exhaust", 0, 0, 16'h0020, 16'h0000,
                  128'h0, 4, 0,
                  1, 16'h0000, 0, 12, 16'h0020, 16'h0003, '0, 0, 3);

    applyStimulus("timeout", 0, 0, 16'h0030, 16'h0000,
                  128'h0, 0, 1,
                  1, 16'h0000, 0, 257, 16'h0030, 16'h0003, '0, 0, 0);

    // Reset in the middle of a bus cycle: no response may follow.
    @(negedge clk);
    silent    = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 16'h0040;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midrst_cyc_before", CYC, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cyc", CYC, 0);
    checkOutput("midrst_stb", STB, 0);
    checkOutput("midrst_resp_valid", resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    silent = 1'b0;
    repeat (5) @(negedge clk);

    applyStimulus("word_store_after_rst", 1, 0, 16'h0035, 16'h5A3C,
                  128'h0, 0, 0,
                  0, 16'h0000, 1, 3, 16'h0030, 16'h0030,
                  128'h00000000_00000000_00005A3C_00000000, 1, 0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
